// File: rtl/full_mem_pkg.sv
// Shared types and helpers for the parametrised memory data block.
package full_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } mem_state_e;

  function automatic int mem_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/full_mem_bank.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module full_mem_bank
  import full_mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  localparam int DEPTH = mem_depth(ADDR_BITS);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // The array is never reset; the owner's init sequencer zero-fills it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/full_mem_data_param.sv
// Memory data block: init sequencer, write mux, write-first bypass, valid-tagged read pipeline.
module full_mem_data_param
  import full_mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 7,
  parameter int OUT_REG   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_req,
  output logic                 ready,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid
);

  // Handshake: ready=1 means a wr_en/rd_en in this cycle is accepted at the
  // next rising edge; each accepted read yields exactly one rd_valid pulse.
  mem_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  logic                 rd_acc, wr_acc;
  logic                 bank_we;
  logic [ADDR_BITS-1:0] bank_waddr;
  logic [WIDTH-1:0]     bank_wdata, bank_rdata;
  logic                 v1_q, byp_q;
  logic [WIDTH-1:0]     byp_data_q;
  logic [WIDTH-1:0]     stage1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_BITS{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        if (init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign ready  = (state_q == IDLE);
  assign rd_acc = rd_en & ready;
  assign wr_acc = wr_en & ready;

  // While initialising, the sequencer owns the write port.
  assign bank_we    = ~ready | wr_acc;
  assign bank_waddr = ready ? wr_addr : cnt_q;
  assign bank_wdata = ready ? wr_data : '0;

  full_mem_bank #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_bank (
    .clk    (clk),
    .we_i   (bank_we),
    .waddr_i(bank_waddr),
    .wdata_i(bank_wdata),
    .re_i   (rd_acc),
    .raddr_i(rd_addr),
    .rdata_o(bank_rdata)
  );

  // The RAM reads old data on a same-address collision, so remember the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q       <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      v1_q       <= rd_acc;
      byp_q      <= rd_acc & wr_acc & (rd_addr == wr_addr);
      byp_data_q <= wr_data;
    end
  end

  assign stage1 = byp_q ? byp_data_q : bank_rdata;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             valid_q;
      logic [WIDTH-1:0] out_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          out_q   <= '0;
        end else begin
          valid_q <= v1_q;
          if (v1_q) out_q <= stage1;
        end
      end

      assign rd_valid = valid_q;
      assign rd_data  = out_q;
    end else begin : g_out_comb
      logic [WIDTH-1:0] hold_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= '0;
        else if (v1_q) hold_q <= stage1;
      end

      assign rd_valid = v1_q;
      assign rd_data  = v1_q ? stage1 : hold_q;
    end
  endgenerate

endmodule
